// File: rtl/bsg_mux_segmented_arb_pkg.sv
// Shared types and helpers for the segmented two-producer arbiter.
// The lane-select enum matches the mux select encoding: 0 = producer 0, 1 = producer 1.
package bsg_mux_segmented_arb_pkg;

  typedef enum logic {e_sel_ch0 = 1'b0, e_sel_ch1 = 1'b1} seg_sel_e;

  function automatic int seg_w(input int width_p, input int segments_p);
    return width_p / segments_p;
  endfunction

endpackage

// File: rtl/bsg_mux_segmented.sv
// Segmented 2:1 mux: each lane independently picks its slice from data0_i or data1_i.
module bsg_mux_segmented #(
  parameter int segments_p      = 4,
  parameter int segment_width_p = 4
) (
  input  logic [segments_p*segment_width_p-1:0] data0_i,
  input  logic [segments_p*segment_width_p-1:0] data1_i,
  input  logic [segments_p-1:0]                 sel_i,
  output logic [segments_p*segment_width_p-1:0] data_o
);

  for (genvar gi = 0; gi < segments_p; gi++) begin : g_lane
    assign data_o[gi*segment_width_p +: segment_width_p] = sel_i[gi]
      ? data1_i[gi*segment_width_p +: segment_width_p]
      : data0_i[gi*segment_width_p +: segment_width_p];
  end

endmodule

// File: rtl/bsg_seg_rr_arb2.sv
// One lane's 2-way round-robin grant; prio_q names the producer that wins the next conflict.
module bsg_seg_rr_arb2
  import bsg_mux_segmented_arb_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_n_i,
  input  logic      v0_i,
  input  logic      v1_i,
  input  logic      en_i,
  output seg_sel_e  grant_o,
  output logic      gnt_v_o
);

  logic prio_q, prio_d;
  logic conflict;

  always_comb begin
    conflict = v0_i & v1_i;
    gnt_v_o  = v0_i | v1_i;
    grant_o  = e_sel_ch0;
    if (conflict) grant_o = seg_sel_e'(prio_q);
    else if (v1_i) grant_o = e_sel_ch1;
    // Only a consumed conflict moves priority, and it always lands on the loser.
    prio_d = prio_q;
    if (conflict && en_i) prio_d = ~prio_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) prio_q <= 1'b0;
    else            prio_q <= prio_d;
  end

endmodule

// File: rtl/bsg_mux_segmented_arb.sv
// Per-lane arbitration of two partial-word producers into a one-entry output register
// with a whole-word valid/ready handshake toward the consumer.
module bsg_mux_segmented_arb
  import bsg_mux_segmented_arb_pkg::*;
#(
  parameter int width_p    = 16,
  parameter int segments_p = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [segments_p-1:0] v0_i,
  input  logic [width_p-1:0]    data0_i,
  output logic [segments_p-1:0] yumi0_o,
  input  logic [segments_p-1:0] v1_i,
  input  logic [width_p-1:0]    data1_i,
  output logic [segments_p-1:0] yumi1_o,
  output logic [segments_p-1:0] v_o,
  output logic [width_p-1:0]    data_o,
  output logic [segments_p-1:0] sel_o,
  input  logic                  ready_i
);

  localparam int seg_w_lp = seg_w(width_p, segments_p);

  if ((width_p % segments_p) != 0) begin : g_bad_width
    $error("width_p must be a multiple of segments_p");
  end

  logic [segments_p-1:0] v_q, v_d;
  logic [width_p-1:0]    data_q, data_d;
  logic [segments_p-1:0] sel_q, sel_d;

  logic                  occupied, deq, load_en;
  seg_sel_e              grant [segments_p];
  logic [segments_p-1:0] gnt_v;
  logic [segments_p-1:0] sel_vec;
  logic [width_p-1:0]    muxed;

  assign occupied = |v_q;
  assign deq      = occupied & ready_i;
  // Gating with reset keeps yumi quiet while the register is held in reset.
  assign load_en  = reset_n_i & (~occupied | deq);

  for (genvar gi = 0; gi < segments_p; gi++) begin : g_lane
    bsg_seg_rr_arb2 u_arb (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v0_i      (v0_i[gi]),
      .v1_i      (v1_i[gi]),
      .en_i      (load_en),
      .grant_o   (grant[gi]),
      .gnt_v_o   (gnt_v[gi])
    );
    assign sel_vec[gi] = (grant[gi] == e_sel_ch1);
    assign yumi0_o[gi] = load_en & gnt_v[gi] & ~sel_vec[gi];
    assign yumi1_o[gi] = load_en & gnt_v[gi] &  sel_vec[gi];
  end

  bsg_mux_segmented #(
    .segments_p      (segments_p),
    .segment_width_p (seg_w_lp)
  ) u_mux (
    .data0_i (data0_i),
    .data1_i (data1_i),
    .sel_i   (sel_vec),
    .data_o  (muxed)
  );

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    sel_d  = sel_q;
    if (load_en) begin
      v_d   = gnt_v;
      sel_d = sel_vec;
      for (int s = 0; s < segments_p; s++) begin
        if (gnt_v[s]) data_d[s*seg_w_lp +: seg_w_lp] = muxed[s*seg_w_lp +: seg_w_lp];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= '0;
      data_q <= '0;
      sel_q  <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;
  assign sel_o  = sel_q;

endmodule
